// File: rtl/sr04_scan_scheduler.sv
// Round-robin HC-SR04 scan controller. It fires one sensor per shot, times the echo of the
// selected sensor, and publishes a result strobe plus a per-sensor "near" flag.
module sr04_scan_scheduler #(
    parameter int N_SENSORS    = 4,
    parameter int TRIG_CYCLES  = 500,
    parameter int ECHO_TIMEOUT = 1500000,
    parameter int GUARD_CYCLES = 500000,
    parameter int CNT_W        = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [CNT_W-1:0]     near_thresh,
    input  logic [N_SENSORS-1:0] echo,
    output logic [N_SENSORS-1:0] trig,
    output logic                 dist_valid,
    output logic [2:0]           dist_idx,
    output logic [CNT_W-1:0]     dist_width,
    output logic                 dist_timeout,
    output logic [N_SENSORS-1:0] near_flags,
    output logic                 busy
);

    localparam int SEL_W  = $clog2(N_SENSORS);
    localparam int MAX_TE = (TRIG_CYCLES > ECHO_TIMEOUT) ? TRIG_CYCLES : ECHO_TIMEOUT;
    localparam int MAX_T  = (MAX_TE > GUARD_CYCLES) ? MAX_TE : GUARD_CYCLES;
    localparam int TMR_W  = $clog2(MAX_T + 1);

    localparam logic [TMR_W-1:0]     TRIG_END  = TMR_W'(TRIG_CYCLES);
    localparam logic [TMR_W-1:0]     WAIT_END  = TMR_W'(ECHO_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]     GUARD_END = TMR_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0]     WIDTH_END = CNT_W'(ECHO_TIMEOUT - 1);
    localparam logic [SEL_W-1:0]     SEL_LAST  = SEL_W'(N_SENSORS - 1);
    localparam logic [N_SENSORS-1:0] ONE_HOT   = N_SENSORS'(1);

    typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_GUARD} state_t;

    state_t               state;
    logic [SEL_W-1:0]     sel;
    logic [TMR_W-1:0]     cnt;
    logic [CNT_W-1:0]     width;
    logic [N_SENSORS-1:0] sync1, sync2;
    logic                 echo_s, echo_prev, rise;
    logic                 report, report_tmo;

    function automatic logic [CNT_W-1:0] sat_width(input logic tmo, input logic [CNT_W-1:0] w);
        return tmo ? {CNT_W{1'b1}} : w;
    endfunction

    function automatic logic is_near(input logic tmo, input logic [CNT_W-1:0] w,
                                     input logic [CNT_W-1:0] thr);
        return !tmo && (w < thr);
    endfunction

    // Echo lines are asynchronous; only the selected sensor's synchronized bit is observed.
    always_ff @(posedge clk) begin
        sync1     <= echo;
        sync2     <= sync1;
        echo_prev <= echo_s;
    end

    assign echo_s = sync2[sel];
    assign rise   = echo_s && !echo_prev;
    assign busy   = (state != S_IDLE);

    always_comb begin
        report     = 1'b0;
        report_tmo = 1'b0;
        case (state)
            S_WAIT_RISE: begin
                if (!rise && cnt == WAIT_END) begin
                    report     = 1'b1;
                    report_tmo = 1'b1;
                end
            end
            S_MEASURE: begin
                if (!echo_s) begin
                    report = 1'b1;
                end else if (width == WIDTH_END) begin
                    report     = 1'b1;
                    report_tmo = 1'b1;
                end
            end
            default: begin
                report     = 1'b0;
                report_tmo = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            sel          <= '0;
            cnt          <= '0;
            width        <= '0;
            trig         <= '0;
            dist_valid   <= 1'b0;
            dist_idx     <= '0;
            dist_width   <= '0;
            dist_timeout <= 1'b0;
            near_flags   <= '0;
        end else begin
            dist_valid <= 1'b0;
            if (report) begin
                dist_valid      <= 1'b1;
                dist_idx        <= 3'(sel);
                dist_width      <= sat_width(report_tmo, width);
                dist_timeout    <= report_tmo;
                near_flags[sel] <= is_near(report_tmo, width, near_thresh);
            end
            case (state)
                S_IDLE: begin
                    trig <= '0;
                    if (enable) begin
                        state <= S_TRIG;
                        cnt   <= '0;
                    end
                end
                S_TRIG: begin
                    // Pulse rises on the first TRIG cycle and drops after TRIG_CYCLES cycles.
                    if (cnt == TRIG_END) begin
                        trig  <= '0;
                        cnt   <= '0;
                        state <= S_WAIT_RISE;
                    end else begin
                        trig <= ONE_HOT << sel;
                        cnt  <= cnt + 1'b1;
                    end
                end
                S_WAIT_RISE: begin
                    if (rise) begin
                        width <= '0;
                        state <= S_MEASURE;
                    end else if (report) begin
                        cnt   <= '0;
                        state <= S_GUARD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_MEASURE: begin
                    if (report) begin
                        cnt   <= '0;
                        state <= S_GUARD;
                    end else begin
                        width <= width + 1'b1;
                    end
                end
                S_GUARD: begin
                    if (cnt == GUARD_END) begin
                        cnt   <= '0;
                        sel   <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
                        state <= enable ? S_TRIG : S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sr04_scan_scheduler.sv
// Randomized bench for sr04_scan_scheduler: a shot-level reference model predicts the
// index, width, timeout and near flags of every result from the echo pulses applied.
`timescale 1ns/1ps
module tb_sr04_scan_scheduler;
    localparam int N = 3, TC = 4, TO = 100, GC = 10, CW = 8;

    logic          clk = 1'b0, reset = 1'b1, enable = 1'b0;
    logic [CW-1:0] near_thresh = '0;
    logic [N-1:0]  echo = '0;
    logic [N-1:0]  trig, near_flags;
    logic          dist_valid, dist_timeout, busy;
    logic [2:0]    dist_idx;
    logic [CW-1:0] dist_width;

    sr04_scan_scheduler #(.N_SENSORS(N), .TRIG_CYCLES(TC), .ECHO_TIMEOUT(TO),
                          .GUARD_CYCLES(GC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .near_thresh(near_thresh), .echo(echo),
        .trig(trig), .dist_valid(dist_valid), .dist_idx(dist_idx), .dist_width(dist_width),
        .dist_timeout(dist_timeout), .near_flags(near_flags), .busy(busy));

    always #5 clk = ~clk;

    typedef struct {int idx; int width; bit tmo; logic [N-1:0] flags; int cyc;} res_t;
    typedef struct {bit got; int trig_w; int idx; int width; bit tmo; logic [N-1:0] flags; int lat;} obs_t;

    res_t         rq[$];
    int           cyc = 0, multi_trig = 0, dv_double = 0, min_gap = 1000000, last_fall = -1;
    logic [N-1:0] prev_trig = '0;
    logic         prev_dv = 1'b0;
    bit           gap_arm = 1'b0, noise_en = 1'b0;
    int           passed = 0, total = 0;
    int           m_sel = 0;
    logic [N-1:0] m_flags = '0;

    // Result capture and trigger-exclusivity / trigger-gap observation.
    always @(negedge clk) begin
        cyc       <= cyc + 1;
        prev_trig <= trig;
        prev_dv   <= dist_valid;
        if ($countones(trig) > 1) multi_trig <= multi_trig + 1;
        if (dist_valid && prev_dv) dv_double <= dv_double + 1;
        if (dist_valid)
            rq.push_back('{int'(dist_idx), int'(dist_width), dist_timeout, near_flags, cyc + 1});
        if (!gap_arm) begin
            min_gap   <= 1000000;
            last_fall <= -1;
        end else begin
            if (trig != '0 && prev_trig == '0 && last_fall >= 0 && (cyc - last_fall) < min_gap)
                min_gap <= cyc - last_fall;
            if (trig == '0 && prev_trig != '0) last_fall <= cyc;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic noise(input int s);
        if (noise_en)
            for (int j = 0; j < N; j++) if (j != s) echo[j[1:0]] = 1'($urandom_range(0, 1));
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        enable = 1'b0;
        echo = '0;
        repeat (3) step();
        reset = 1'b0;
        rq.delete();
        m_sel = 0;
        m_flags = '0;
    endtask

    // mode: 0 echo pulse, 1 silent, 2 stuck high, 3 over-long pulse
    task automatic drive_shot(input int s, input int mode, input int d, input int len,
                              input int drop_at, output obs_t o);
        int n, t0;
        res_t r;
        o = '{default: 0};
        if (mode == 2) echo[s[1:0]] = 1'b1;
        n = 0;
        while (trig[s[1:0]] !== 1'b1 && n < 3000) begin step(); n++; end
        if (n >= 3000) begin
            if (mode == 2) echo[s[1:0]] = 1'b0;
            return;
        end
        while (trig[s[1:0]] === 1'b1 && o.trig_w < 50) begin step(); o.trig_w++; end
        t0 = cyc;
        if (mode == 0 || mode == 3) begin
            for (int i = 0; i < d; i++) begin noise(s); step(); end
            echo[s[1:0]] = 1'b1;
            for (int i = 0; i < len; i++) begin
                if (i == drop_at) enable = 1'b0;
                noise(s);
                step();
            end
            echo[s[1:0]] = 1'b0;
        end
        for (int j = 0; j < N; j++) if (j != s) echo[j[1:0]] = 1'b0;
        n = 0;
        while (rq.size() == 0 && n < 400) begin step(); n++; end
        if (mode == 2) echo[s[1:0]] = 1'b0;
        if (rq.size() == 0) return;
        r = rq.pop_front();
        o.got = 1'b1; o.idx = r.idx; o.width = r.width; o.tmo = r.tmo; o.flags = r.flags;
        o.lat = r.cyc - t0;
    endtask

    task automatic test_reset();
        apply_reset();
        step();
        total++; if ({trig, dist_valid, dist_idx, dist_width, dist_timeout, near_flags} !== '0)
            $display("FAIL reset_outputs: got trig=%b dv=%b idx=%0d w=%0d tmo=%b nf=%b, want all 0",
                     trig, dist_valid, dist_idx, dist_width, dist_timeout, near_flags);
        else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_single_shot();
        obs_t o;
        int dv0 = dv_double;
        near_thresh = 8'd25;
        enable = 1'b1;
        drive_shot(0, 0, 5, 20, -1, o);
        m_flags[0] = 1'b1; m_sel = 1;
        total++; if (!o.got) $display("FAIL single_result: got none want one"); else passed++;
        total++; if (o.trig_w !== TC) $display("FAIL single_trig_w: got %0d want %0d", o.trig_w, TC); else passed++;
        total++; if (o.idx !== 0 || o.tmo !== 1'b0)
            $display("FAIL single_idx_tmo: got idx=%0d tmo=%b want idx=0 tmo=0", o.idx, o.tmo);
        else passed++;
        total++; if (o.width < 19 || o.width > 21) $display("FAIL single_width: got %0d want 20+-1", o.width); else passed++;
        total++; if (dv_double !== dv0) $display("FAIL single_dv_once: got %0d extra strobes want 0", dv_double - dv0); else passed++;
    endtask

    task automatic test_round_robin();
        obs_t o;
        int mt0;
        apply_reset();
        near_thresh = 8'd25;
        gap_arm = 1'b1;
        mt0 = multi_trig;
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_shot(k % N, 0, int'($urandom_range(2, 10)), 30, -1, o);
            total++; if (!o.got || o.idx !== k % N || o.width < 29 || o.width > 31)
                $display("FAIL rr_shot%0d: got got=%b idx=%0d w=%0d want idx=%0d w=30+-1", k, o.got, o.idx, o.width, k % N);
            else passed++;
        end
        m_sel = 1;
        total++; if (multi_trig !== mt0) $display("FAIL rr_onehot: got %0d multi-trig cycles want 0", multi_trig - mt0); else passed++;
        total++; if (min_gap < GC || min_gap == 1000000) $display("FAIL rr_gap: got min gap %0d want >= %0d", min_gap, GC); else passed++;
        gap_arm = 1'b0;
    endtask

    task automatic test_no_echo();
        obs_t o;
        drive_shot(1, 1, 0, 0, -1, o);
        m_flags[1] = 1'b0; m_sel = 2;
        total++; if (!o.got || o.idx !== 1 || o.tmo !== 1'b1 || o.width !== 255)
            $display("FAIL noecho_result: got got=%b idx=%0d tmo=%b w=%0d want idx=1 tmo=1 w=255", o.got, o.idx, o.tmo, o.width);
        else passed++;
        total++; if (o.lat < TO - 1 || o.lat > TO + 1) $display("FAIL noecho_latency: got %0d want %0d+-1", o.lat, TO); else passed++;
        total++; if (o.flags[1] !== 1'b0) $display("FAIL noecho_flag: got %b want 0", o.flags[1]); else passed++;
    endtask

    task automatic test_stuck_high();
        obs_t o;
        drive_shot(2, 2, 0, 0, -1, o);
        m_flags[2] = 1'b0;
        total++; if (!o.got || o.idx !== 2 || o.tmo !== 1'b1 || o.width !== 255)
            $display("FAIL stuck_result: got got=%b idx=%0d tmo=%b w=%0d want idx=2 tmo=1 w=255", o.got, o.idx, o.tmo, o.width);
        else passed++;
        drive_shot(0, 0, 3, 15, -1, o);
        m_flags[0] = 1'b1; m_sel = 1;
        total++; if (!o.got || o.idx !== 0 || o.width < 14 || o.width > 16)
            $display("FAIL stuck_next: got got=%b idx=%0d w=%0d want idx=0 w=15+-1", o.got, o.idx, o.width);
        else passed++;
        total++; if (o.flags !== m_flags) $display("FAIL stuck_flags: got %b want %b", o.flags, m_flags); else passed++;
    endtask

    task automatic test_near_flags();
        obs_t o;
        int lens[4] = '{10, 40, 10, 40};
        apply_reset();
        near_thresh = 8'd25;
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_shot(k % N, 0, 4, lens[k], -1, o);
            m_flags[k % N] = (lens[k] < 25);
            total++; if (!o.got || o.flags !== m_flags)
                $display("FAIL near_shot%0d: got got=%b flags=%b want %b", k, o.got, o.flags, m_flags);
            else passed++;
        end
        m_sel = 1;
        total++; if (near_flags !== 3'b100) $display("FAIL near_final: got %b want 100", near_flags); else passed++;
    endtask

    task automatic test_random();
        obs_t o;
        int mode, len, thr, d, dv0;
        bit exp_tmo;
        noise_en = 1'b1;
        dv0 = dv_double;
        for (int k = 0; k < 14; k++) begin
            thr = int'($urandom_range(10, 70));
            near_thresh = CW'(thr);
            case ($urandom_range(0, 9))
                0: begin mode = 1; len = 0; d = 0; end
                1: begin mode = 3; len = 105; d = int'($urandom_range(0, 10)); end
                default: begin
                    mode = 0;
                    d = int'($urandom_range(0, 40));
                    do len = int'($urandom_range(2, 80)); while (len >= thr - 2 && len <= thr + 2);
                end
            endcase
            exp_tmo = (mode != 0);
            drive_shot(m_sel, mode, d, len, -1, o);
            m_flags[m_sel[1:0]] = !exp_tmo && (len < thr);
            total++; if (!o.got || o.trig_w !== TC || o.idx !== m_sel || o.tmo !== exp_tmo)
                $display("FAIL rand%0d_shot: got got=%b trig_w=%0d idx=%0d tmo=%b want trig_w=%0d idx=%0d tmo=%b",
                         k, o.got, o.trig_w, o.idx, o.tmo, TC, m_sel, exp_tmo);
            else passed++;
            total++; if (exp_tmo ? (o.width !== 255) : (o.width < len - 1 || o.width > len + 1))
                $display("FAIL rand%0d_width: got %0d want %0d (tmo=%b)", k, o.width, exp_tmo ? 255 : len, exp_tmo);
            else passed++;
            total++; if (o.flags !== m_flags) $display("FAIL rand%0d_flags: got %b want %b", k, o.flags, m_flags); else passed++;
            m_sel = (m_sel + 1) % N;
        end
        noise_en = 1'b0;
        total++; if (dv_double !== dv0) $display("FAIL rand_dv_once: got %0d extra strobes want 0", dv_double - dv0); else passed++;
    endtask

    task automatic test_enable_drop();
        obs_t o;
        int s = m_sel;
        near_thresh = 8'd25;
        drive_shot(s, 0, 5, 30, 10, o);
        m_flags[s[1:0]] = 1'b0;
        total++; if (!o.got || o.idx !== s || o.width < 29 || o.width > 31)
            $display("FAIL drop_result: got got=%b idx=%0d w=%0d want idx=%0d w=30+-1", o.got, o.idx, o.width, s);
        else passed++;
        repeat (GC + 5) step();
        total++; if (busy !== 1'b0 || trig !== '0) $display("FAIL drop_idle: got busy=%b trig=%b want 0/000", busy, trig); else passed++;
        enable = 1'b1;
        m_sel = (s + 1) % N;
        drive_shot(m_sel, 0, 5, 12, -1, o);
        m_flags[m_sel[1:0]] = 1'b1;
        total++; if (!o.got || o.idx !== m_sel)
            $display("FAIL drop_resume: got got=%b idx=%0d want idx=%0d", o.got, o.idx, m_sel);
        else passed++;
        m_sel = (m_sel + 1) % N;
    endtask

    task automatic test_reset_mid_trig();
        int n = 0;
        total++; if (near_flags !== m_flags) $display("FAIL rst_pre_flags: got %b want %b", near_flags, m_flags); else passed++;
        while (trig === '0 && n < 300) begin step(); n++; end
        total++; if (trig[m_sel[1:0]] !== 1'b1) $display("FAIL rst_trig_seen: got trig=%b want sensor %0d high", trig, m_sel); else passed++;
        reset = 1'b1;
        step();
        total++; if (trig !== '0) $display("FAIL rst_trig_drop: got %b want 000", trig); else passed++;
        total++; if ({dist_valid, dist_idx, dist_width, dist_timeout, near_flags, busy} !== '0)
            $display("FAIL rst_outputs: got dv=%b idx=%0d w=%0d tmo=%b nf=%b busy=%b want all 0",
                     dist_valid, dist_idx, dist_width, dist_timeout, near_flags, busy);
        else passed++;
        enable = 1'b0;
        step();
        reset = 1'b0;
        rq.delete();
        repeat (150) step();
        total++; if (rq.size() != 0) $display("FAIL rst_no_result: got %0d results want 0", rq.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_round_robin();
        test_no_echo();
        test_stuck_high();
        test_near_flags();
        test_random();
        test_enable_drop();
        test_reset_mid_trig();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
